// File: rtl/uart_pkg.sv
// Shared types for the UART bus host: register map, host FSM states
// and the field positions of the peripheral's status words.
package uart_pkg;

    typedef enum logic [31:0] {
        RX_STATE = 32'd0,
        RX_DATA  = 32'd4,
        TX_STATE = 32'd8,
        TX_DATA  = 32'd12
    } regAddr_t;

    typedef enum logic [3:0] {
        INIT_RX,
        INIT_TX,
        IDLE,
        RX_RD,
        RX_CAP,
        RX_PUSH,
        TX_STAT,
        TX_CHK,
        TX_WR
    } hostState_t;

    localparam int COUNT_MSB   = 31;
    localparam int COUNT_LSB   = 24;
    localparam int STATUS_DONE = 0;

    function automatic logic [1:0] clampThree(input logic [7:0] n);
        return (n > 8'd3) ? 2'd3 : n[1:0];
    endfunction

endpackage

// File: rtl/uart_byte_fifo.sv
// Byte FIFO with single push and a bulk pop of up to three entries;
// the three head entries are visible so a caller can pack them.
module uart_byte_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pushEn,
    input  logic [7:0]               pushData,
    input  logic [1:0]               popCnt,
    output logic [7:0]               head0,
    output logic [7:0]               head1,
    output logic [7:0]               head2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr;
    logic [AW-1:0] rdPtr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (pushEn) wrPtr <= wrPtr + AW'(1);
            rdPtr <= rdPtr + AW'(popCnt);
            count <= count + CW'(pushEn) - CW'(popCnt);
        end
    end

    always_ff @(posedge clk) begin
        if (pushEn) mem[wrPtr] <= pushData;
    end

    assign head0 = mem[rdPtr];
    assign head1 = mem[rdPtr + AW'(1)];
    assign head2 = mem[rdPtr + AW'(2)];
    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);

endmodule

// File: rtl/uart_bus_host.sv
// Bus initiator for the UART peripheral: programs both baud rates once,
// then polls RX and TX in turn, bridging bytes to valid/ready streams.
module uart_bus_host #(
    parameter int RX_RATE  = 324,
    parameter int TX_RATE  = 5207,
    parameter int RX_DEPTH = 8,
    parameter int TX_DEPTH = 4,
    parameter int POLL_GAP = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        overrun,
    output logic        bus_error,
    output logic        ren,
    output logic        wen,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  strobe,
    input  logic [31:0] rdata,
    input  logic        request_stall,
    input  logic        error
);

    import uart_pkg::*;

    localparam int RAW = $clog2(RX_DEPTH);
    localparam int TAW = $clog2(TX_DEPTH);
    localparam int GW  = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam logic [GW-1:0]  GAP_MAX    = GW'(POLL_GAP);
    localparam logic [RAW:0]   RX_ELIG_MAX = (RAW + 1)'(RX_DEPTH - 3);
    localparam logic [15:0]    RX_RATE16  = 16'(RX_RATE);
    localparam logic [15:0]    TX_RATE16  = 16'(TX_RATE);

    hostState_t    state;
    logic [GW-1:0] gapCnt;
    logic          rxTurn;
    logic [23:0]   rxBytes;
    logic [1:0]    rxN;
    logic [1:0]    rxIdx;
    logic [1:0]    txK;

    logic [RAW:0]  rxCount;
    logic [TAW:0]  txCount;
    logic          rxEmpty;
    logic          txFull;
    logic          txEmpty;
    logic [7:0]    txHead0;
    logic [7:0]    txHead1;
    logic [7:0]    txHead2;
    logic [7:0]    rxPushData;
    logic [1:0]    rxCapN;
    logic [1:0]    txAvail;
    logic [31:0]   txWord;
    logic          accepted;
    logic          rxPush;
    logic          rxPop;
    logic          txPush;
    logic [1:0]    txPopCnt;
    logic          goRx;
    logic          goTx;
    logic [7:0]    unusedRxHead1;
    logic [7:0]    unusedRxHead2;
    logic          unusedRxFull;

    assign accepted = (ren | wen) & ~request_stall;
    assign tx_ready = ~reset & ~txFull;
    assign rx_valid = ~rxEmpty;
    assign txPush   = tx_valid & tx_ready;
    assign rxPop    = rx_valid & rx_ready;
    assign rxPush   = (state == RX_PUSH);
    assign txPopCnt = (state == TX_WR && accepted) ? txK : 2'd0;
    assign rxCapN   = clampThree(rdata[COUNT_MSB:COUNT_LSB]);
    assign txAvail  = clampThree(8'(txCount));

    // Turn order is only a preference; an ineligible side yields its slot.
    assign goRx = (rxCount <= RX_ELIG_MAX) & (rxTurn | txEmpty);
    assign goTx = ~txEmpty & ~goRx;

    assign txWord = {6'd0, txAvail,
                     (txAvail == 2'd3) ? txHead2 : 8'h00,
                     (txAvail >= 2'd2) ? txHead1 : 8'h00,
                     txHead0};

    always_comb begin
        rxPushData = rxBytes[7:0];
        unique case (rxIdx)
            2'd1:    rxPushData = rxBytes[15:8];
            2'd2:    rxPushData = rxBytes[23:16];
            default: rxPushData = rxBytes[7:0];
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= INIT_RX;
            ren       <= 1'b0;
            wen       <= 1'b0;
            addr      <= '0;
            wdata     <= '0;
            strobe    <= '0;
            gapCnt    <= '0;
            rxTurn    <= 1'b1;
            rxBytes   <= '0;
            rxN       <= '0;
            rxIdx     <= '0;
            txK       <= '0;
            overrun   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            if (accepted && error) bus_error <= 1'b1;
            unique case (state)
                INIT_RX: begin
                    if (!wen) begin
                        wen    <= 1'b1;
                        addr   <= RX_STATE;
                        strobe <= 4'b1100;
                        wdata  <= {RX_RATE16, 16'h0};
                    end else if (accepted) begin
                        wen   <= 1'b0;
                        state <= INIT_TX;
                    end
                end
                INIT_TX: begin
                    if (!wen) begin
                        wen    <= 1'b1;
                        addr   <= TX_STATE;
                        strobe <= 4'b1100;
                        wdata  <= {TX_RATE16, 16'h0};
                    end else if (accepted) begin
                        wen   <= 1'b0;
                        state <= IDLE;
                    end
                end
                IDLE: begin
                    if (gapCnt != GAP_MAX) begin
                        gapCnt <= gapCnt + GW'(1);
                    end else begin
                        gapCnt <= '0;
                        unique case (1'b1)
                            goRx: begin
                                state  <= RX_RD;
                                rxTurn <= 1'b0;
                            end
                            goTx: begin
                                state  <= TX_STAT;
                                rxTurn <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RX_RD: begin
                    if (!ren) begin
                        ren    <= 1'b1;
                        addr   <= RX_DATA;
                        strobe <= 4'b1111;
                        wdata  <= '0;
                    end else if (accepted) begin
                        ren   <= 1'b0;
                        state <= RX_CAP;
                    end
                end
                RX_CAP: begin
                    if (rdata[COUNT_MSB:COUNT_LSB] > 8'd3) overrun <= 1'b1;
                    rxBytes <= rdata[23:0];
                    rxN     <= rxCapN;
                    rxIdx   <= '0;
                    state   <= (rxCapN == 2'd0) ? IDLE : RX_PUSH;
                end
                RX_PUSH: begin
                    rxIdx <= rxIdx + 2'd1;
                    if (rxIdx == rxN - 2'd1) state <= IDLE;
                end
                TX_STAT: begin
                    if (!ren) begin
                        ren    <= 1'b1;
                        addr   <= TX_STATE;
                        strobe <= 4'b1111;
                        wdata  <= '0;
                    end else if (accepted) begin
                        ren   <= 1'b0;
                        state <= TX_CHK;
                    end
                end
                TX_CHK: begin
                    // The packed word and pop count are frozen here so
                    // pushes during the write cannot change them.
                    if (rdata[STATUS_DONE]) begin
                        txK    <= txAvail;
                        wen    <= 1'b1;
                        addr   <= TX_DATA;
                        strobe <= 4'b1111;
                        wdata  <= txWord;
                        state  <= TX_WR;
                    end else begin
                        state <= IDLE;
                    end
                end
                TX_WR: begin
                    if (accepted) begin
                        wen   <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    uart_byte_fifo #(.DEPTH(RX_DEPTH)) rxFifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (rxPush),
        .pushData (rxPushData),
        .popCnt   ({1'b0, rxPop}),
        .head0    (rx_data),
        .head1    (unusedRxHead1),
        .head2    (unusedRxHead2),
        .count    (rxCount),
        .full     (unusedRxFull),
        .empty    (rxEmpty)
    );

    uart_byte_fifo #(.DEPTH(TX_DEPTH)) txFifo (
        .clk      (clk),
        .reset    (reset),
        .pushEn   (txPush),
        .pushData (tx_data),
        .popCnt   (txPopCnt),
        .head0    (txHead0),
        .head1    (txHead1),
        .head2    (txHead2),
        .count    (txCount),
        .full     (txFull),
        .empty    (txEmpty)
    );

endmodule

// File: tb/tb_uart_bus_host.sv
// Bench for uart_bus_host: a scripted peripheral plus a queue-based model
// of expected bus writes, delivered bytes and sticky flags.
module tb_uart_bus_host;

    localparam int RXD = 8;
    localparam int TXD = 4;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int          k;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  tx_data = 8'h00;
    logic        tx_valid = 1'b0;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        overrun;
    logic        bus_error;
    logic        ren;
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strobe;
    logic [31:0] rdata = 32'h0;
    logic        request_stall = 1'b0;
    logic        error = 1'b0;

    int checks = 0;
    int errors = 0;

    wr_t         expWr[$];
    logic [7:0]  txQ[$];
    logic [7:0]  rxExp[$];
    logic [7:0]  rxLog[$];
    logic [31:0] txLog[$];
    logic [31:0] rxResp[$];
    logic [31:0] txResp[$];
    bit          ovSet = 0;
    bit          beSet = 0;
    bit          errArm = 0;
    bit          stallArm = 0;
    int          stallLeft = 0;
    int          stallSeen = 0;
    int          rxReads = 0;
    int          txPolls = 0;

    uart_bus_host dut (
        .clk           (clk),
        .reset         (reset),
        .tx_data       (tx_data),
        .tx_valid      (tx_valid),
        .tx_ready      (tx_ready),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .rx_ready      (rx_ready),
        .overrun       (overrun),
        .bus_error     (bus_error),
        .ren           (ren),
        .wen           (wen),
        .addr          (addr),
        .wdata         (wdata),
        .strobe        (strobe),
        .rdata         (rdata),
        .request_stall (request_stall),
        .error         (error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Peripheral + monitor: everything sampled and driven on negedge.
    bit          pendRd = 0;
    logic [31:0] pendAddr = 0;
    bit          prevAcc = 0;
    bit          prevStall = 0;
    logic [71:0] snap = '0;
    initial begin
        logic [31:0] r;
        logic [31:0] w;
        int          cnt;
        int          n;
        int          k;
        bit          acc;
        wr_t         e;
        forever begin
            @(negedge clk);
            if (reset) begin
                rdata = 0; request_stall = 0; error = 0;
                pendRd = 0; prevAcc = 0; prevStall = 0;
                continue;
            end
            chk("overrun", overrun, ovSet);
            chk("bus_error", bus_error, beSet);
            chk("one_hot_req", ren & wen, 0);
            if (prevAcc) chk("req_drop", ren | wen, 0);
            if (prevStall)
                chk("stall_hold", (snap == {ren, wen, addr, wdata, strobe, 2'b0}), 1);
            chk("tx_ready", tx_ready, txQ.size() < TXD);
            if (rx_valid) begin
                if (rxExp.size() == 0) begin
                    chk("rx_spurious", rx_valid, 0);
                end else begin
                    chk("rx_data", rx_data, rxExp[0]);
                    if (rx_ready) begin
                        rxLog.push_back(rx_data);
                        void'(rxExp.pop_front());
                    end
                end
            end
            if (pendRd) begin
                if (pendAddr == 32'd4) begin
                    r = (rxResp.size() != 0) ? rxResp[0] : 32'h005A5A5A;
                    if (rxResp.size() != 0) void'(rxResp.pop_front());
                    cnt = int'(r[31:24]);
                    n = (cnt > 3) ? 3 : cnt;
                    for (int i = 0; i < n; i++) rxExp.push_back(r[8*i +: 8]);
                    if (cnt > 3) ovSet = 1;
                end else begin
                    r = (txResp.size() != 0) ? txResp[0] : 32'hFFFFFFFE;
                    if (txResp.size() != 0) void'(txResp.pop_front());
                    txPolls++;
                    if (r[0] && txQ.size() != 0) begin
                        k = (txQ.size() > 3) ? 3 : txQ.size();
                        w = {8'(k), (k >= 3) ? txQ[2] : 8'h00,
                             (k >= 2) ? txQ[1] : 8'h00, txQ[0]};
                        expWr.push_back('{32'd12, w, 4'hF, k});
                    end
                end
                rdata = r;
            end else begin
                rdata = 32'hDEADBEEF;
            end
            if (tx_valid && tx_ready) txQ.push_back(tx_data);
            if (stallArm && (ren || wen)) begin
                stallLeft = 5;
                stallArm = 0;
            end
            request_stall = (stallLeft > 0);
            if (stallLeft > 0) begin
                stallLeft--;
                stallSeen++;
            end
            acc = (ren || wen) && !request_stall;
            error = errArm && acc && ren;
            if (error) begin
                errArm = 0;
                beSet = 1;
            end
            if (acc && wen) begin
                if (expWr.size() == 0) begin
                    chk("unexpected_write_addr", addr, 32'hFFFFFFFF);
                end else begin
                    e = expWr.pop_front();
                    chk("wr_addr", addr, e.a);
                    chk("wr_data", wdata, e.d);
                    chk("wr_strobe", 32'(strobe), 32'(e.s));
                    if (e.a == 32'd12) begin
                        txLog.push_back(wdata);
                        for (int i = 0; i < e.k; i++) void'(txQ.pop_front());
                    end
                end
            end
            if (acc && ren) begin
                chk("rd_addr", (addr == 32'd4 || addr == 32'd8), 1);
                chk("rd_after_init", expWr.size() < 2, 1);
                if (addr == 32'd4) begin
                    rxReads++;
                    chk("rx_elig", rxExp.size() <= RXD - 3, 1);
                end
            end
            pendRd = acc && ren;
            pendAddr = addr;
            prevAcc = acc;
            prevStall = request_stall && (ren || wen);
            snap = {ren, wen, addr, wdata, strobe, 2'b0};
        end
    end

    task automatic pushByte(input logic [7:0] b);
        bit done = 0;
        @(posedge clk); #1;
        tx_data = b;
        tx_valid = 1'b1;
        for (int t = 0; t < 400 && !done; t++) begin
            @(negedge clk);
            if (tx_ready) done = 1;
        end
        chk("push_timeout", done, 1);
        @(posedge clk); #1;
        tx_valid = 1'b0;
    endtask

    initial begin
        int rd0;
        expWr.push_back('{32'd0, 32'h0144_0000, 4'hC, 0});
        expWr.push_back('{32'd8, 32'h1457_0000, 4'hC, 0});
        repeat (3) @(negedge clk);
        chk("rst_ren", ren, 0);
        chk("rst_wen", wen, 0);
        chk("rst_addr", addr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_strobe", 32'(strobe), 0);
        chk("rst_tx_ready", tx_ready, 0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_bus_error", bus_error, 0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_tx_ready", tx_ready, 1);
        for (int t = 0; t < 50 && expWr.size() != 0; t++) @(negedge clk);
        chk("init_writes_done", expWr.size(), 0);

        rxResp.push_back(32'h0343_4241);
        for (int t = 0; t < 300 && rxLog.size() < 3; t++) @(negedge clk);
        chk("rx1_count", rxLog.size(), 3);
        chk("rx1_overrun", overrun, 0);

        rxResp.push_back(32'h0533_2211);
        for (int t = 0; t < 300 && rxLog.size() < 6; t++) @(negedge clk);
        chk("rx2_count", rxLog.size(), 6);
        @(negedge clk);
        chk("rx2_overrun", overrun, 1);

        for (int i = 0; i < 4; i++) pushByte(8'hA0 + 8'(i));
        repeat (120) @(negedge clk);
        chk("tx_nodone_writes", txLog.size(), 0);
        chk("tx_nodone_polled", txPolls >= 2, 1);
        txResp.push_back(32'h1);
        txResp.push_back(32'h1);
        pushByte(8'hA4);
        for (int t = 0; t < 400 && txLog.size() < 2; t++) @(negedge clk);
        chk("tx_write_count", txLog.size(), 2);
        if (txLog.size() >= 2) begin
            chk("tx_word0", txLog[0], 32'h03A2_A1A0);
            chk("tx_word1", txLog[1], 32'h0200_A4A3);
        end

        stallArm = 1;
        for (int t = 0; t < 200 && (stallArm || stallLeft != 0); t++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("stall_cycles", stallSeen, 5);

        errArm = 1;
        for (int t = 0; t < 200 && errArm; t++) @(negedge clk);
        repeat (2) @(negedge clk);
        chk("bus_error_set", bus_error, 1);

        @(posedge clk); #1;
        rx_ready = 1'b0;
        rxResp.push_back(32'h03C2_C1C0);
        rxResp.push_back(32'h0200_C4C3);
        rxResp.push_back(32'h03C7_C6C5);
        rxResp.push_back(32'h0100_00C8);
        for (int t = 0; t < 400 && rxExp.size() < 8; t++) @(negedge clk);
        repeat (10) @(negedge clk);
        rd0 = rxReads;
        repeat (100) @(negedge clk);
        chk("rx_full_no_reads", rxReads - rd0, 0);
        chk("rx_full_valid", rx_valid, 1);
        chk("rx_full_head", rx_data, 8'hC0);
        chk("rx_full_pending", rxResp.size(), 1);
        @(posedge clk); #1;
        rx_ready = 1'b1;
        for (int t = 0; t < 500 && rxLog.size() < 15; t++) @(negedge clk);
        chk("rx_total", rxLog.size(), 15);
        if (rxLog.size() >= 15) begin
            chk("rx_first", rxLog[0], 8'h41);
            chk("rx_ovr_last", rxLog[5], 8'h33);
            chk("rx_last", rxLog[14], 8'hC8);
        end

        repeat (5) @(negedge clk);
        chk("end_exp_writes", expWr.size(), 0);
        chk("end_rx_model", rxExp.size(), 0);
        chk("end_overrun", overrun, 1);
        chk("end_bus_error", bus_error, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
        $fatal(1);
    end

endmodule
